// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: a request is accepted, then shifted by at most
// seven bit positions per cycle until the full distance is reached, and the
// result is held until the consumer takes it.
module shift_sequencer #(
  parameter int N = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [3:0]   in_amount,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_carry,
  output logic         out_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [N-1:0]   acc;
  logic [3:0]     remain;
  logic           dir;
  logic           carry;

  logic [2:0]     step;
  logic [3:0]     remain_nxt;
  logic [N-1:0]   shifted;
  logic           step_carry;

  // 3-bit-amount logical shifter with zero fill; right when dir is set.
  function automatic logic [N-1:0] shift3(input logic [N-1:0] d,
                                          input logic [2:0]   amt,
                                          input logic         right);
    if (right)
      return d >> amt;
    else
      return d << amt;
  endfunction

  // Last bit pushed out by shift3: bit N-amt (left) or bit amt-1 (right).
  // Shifting by amt-1 moves that bit to the edge where it can be picked up.
  function automatic logic shift3_out(input logic [N-1:0] d,
                                      input logic [2:0]   amt,
                                      input logic         right);
    logic [N-1:0] t;
    if (amt == 3'd0)
      return 1'b0;
    if (right) begin
      t = d >> (amt - 3'd1);
      return t[0];
    end
    t = d << (amt - 3'd1);
    return t[N-1];
  endfunction

  // Per-pass step size, remaining distance and shifter result.
  always_comb begin
    step       = (remain > 4'd7) ? 3'd7 : remain[2:0];
    remain_nxt = remain - {1'b0, step};
    shifted    = shift3(acc, step, dir);
    step_carry = shift3_out(acc, step, dir);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        if (remain_nxt == 4'd0)
          state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on acceptance and one shifter pass per SHIFT cycle.
  // Reset clears the datapath so a discarded request leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      remain <= '0;
      dir    <= 1'b0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= in_data;
            remain <= in_amount;
            dir    <= in_dir;
            carry  <= 1'b0;
          end
        end
        SHIFT: begin
          acc    <= shifted;
          remain <= remain_nxt;
          if (step != 3'd0)
            carry <= step_carry;
        end
        default: ;
      endcase
    end
  end

  assign out_data  = acc;
  assign out_carry = carry;
  assign out_zero  = (acc == '0);

endmodule
